// File: rtl/tt_sweep_capture_pkg.sv
// ---------------------------------------------------------------------------
// tt_sweep_pkg
//   Shared definitions for the truth-table sweep/capture block.
//   - N_IN_DEF     : default number of function inputs
//   - SETTLE_W     : width of the settle counter (SETTLE range 0..15)
//   - tt_width()   : truth-table width for a given input count (2**n)
//   - sweep_state_t: FSM state encoding used by tt_sweep_capture
// ---------------------------------------------------------------------------
package tt_sweep_pkg;

  localparam int N_IN_DEF = 4;
  localparam int SETTLE_W = 4;

  // One truth-table bit per input minterm.
  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/tt_sweep_capture_settle_timer.sv
// ---------------------------------------------------------------------------
// tt_settle_timer
//   Loadable down-counter that paces the settle time between driving a new
//   minterm and sampling the function output.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset (count -> 0)
//   load     in  load count with load_val (has priority over en)
//   load_val in  W-bit reload value
//   en       in  decrement enable (saturates at 0)
//   done     out high on the last wait cycle (count <= 1)
// ---------------------------------------------------------------------------
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: reload wins, otherwise count down towards zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A count of 1 means this is the final wait cycle; 0 is treated the same
  // so a timer that was never loaded cannot stall the FSM.
  assign done = (count_q <= W'(1));

endmodule

// File: rtl/tt_sweep_capture.sv
// ---------------------------------------------------------------------------
// tt_sweep_capture
//   Drives every input minterm of an N_IN-input combinational function block,
//   waits SETTLE cycles per minterm, samples fn_y and assembles the truth
//   table (bit i = f(i)). The table is handed downstream with valid/ready.
// Parameters:
//   N_IN    number of function inputs (truth table is 2**N_IN bits)
//   SETTLE  wait cycles after fn_x changes before fn_y is sampled (0..15)
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, aborts any sweep
//   start     in   sweep request, accepted only in IDLE
//   busy      out  high from accept until the tt_valid/tt_ready handshake
//   fn_x      out  minterm driven to the function block
//   fn_y      in   function block output
//   tt        out  captured truth table, stable while tt_valid
//   tt_valid  out  truth table available
//   tt_ones   out  onset count of tt (only with TT_SWEEP_POPCOUNT_EN)
//   tt_ready  in   downstream accepts tt
// Configuration:
//   TT_SWEEP_POPCOUNT_EN  adds the tt_ones output and its accumulator.
// ---------------------------------------------------------------------------
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic [N_IN-1:0]           fn_x,
  input  logic                      fn_y,
  output logic [tt_width(N_IN)-1:0] tt,
  output logic                      tt_valid,
`ifdef TT_SWEEP_POPCOUNT_EN
  output logic [N_IN:0]             tt_ones,
`endif
  input  logic                      tt_ready
);

  localparam int                  TT_W     = tt_width(N_IN);
  localparam logic [N_IN-1:0]     IDX_LAST = N_IN'(TT_W - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);
  localparam bit                  HAS_WAIT = (SETTLE != 0);

  sweep_state_t    state_q;
  sweep_state_t    state_d;
  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] idx_d;
  logic [TT_W-1:0] tt_q;
  logic [TT_W-1:0] tt_d;
  logic            tt_valid_q;
  logic            tt_valid_d;

  logic            timer_load;
  logic            timer_en;
  logic            timer_done;

  tt_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_V),
    .en       (timer_en),
    .done     (timer_done)
  );

  // Sweep FSM and capture datapath. Each minterm spends SETTLE cycles in
  // WAIT followed by one SAMPLE cycle, so fn_x is held SETTLE+1 cycles.
  // tt_valid is registered from the DONE state, which adds the one extra
  // cycle between the final sample and the table being presented.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tt_d       = tt_q;
    tt_valid_d = tt_valid_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d      = '0;
          timer_load = 1'b1;
          state_d    = HAS_WAIT ? WAIT : SAMPLE;
        end
      end

      WAIT: begin
        timer_en = 1'b1;
        if (timer_done) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        tt_d[idx_q] = fn_y;
        // The terminal compare ends the sweep; idx never wraps.
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d      = idx_q + N_IN'(1);
          timer_load = 1'b1;
          state_d    = HAS_WAIT ? WAIT : SAMPLE;
        end
      end

      DONE: begin
        // start is not looked at here, so a start coinciding with the
        // handshake is dropped rather than queued.
        if (tt_valid_q && tt_ready) begin
          tt_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          tt_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tt_q       <= '0;
      tt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tt_q       <= tt_d;
      tt_valid_q <= tt_valid_d;
    end
  end

  // fn_x tracks idx directly, so it only moves when a new minterm starts.
  assign fn_x     = idx_q;
  assign tt       = tt_q;
  assign tt_valid = tt_valid_q;
  assign busy     = (state_q != IDLE);

`ifdef TT_SWEEP_POPCOUNT_EN
  logic [N_IN:0] ones_q;
  logic [N_IN:0] ones_d;

  // Onset counter: cleared when a sweep is accepted, bumped by fn_y on
  // every sample, so it is complete by the time tt_valid rises.
  always_comb begin
    ones_d = ones_q;
    if ((state_q == IDLE) && start) begin
      ones_d = '0;
    end else if (state_q == SAMPLE) begin
      ones_d = ones_q + (N_IN + 1)'(fn_y);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign tt_ones = ones_q;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_capture
//   Three copies of tt_sweep_capture with SETTLE = 0, 1, 2 share one clock,
//   reset and tt_ready; each has its own start and its own function model.
//   A table of sweeps is applied in a loop, expected results go through a
//   scoreboard queue, and hand-written sequences cover repeated start
//   pulses, DONE back-pressure, and reset in the middle of a sweep.
// ---------------------------------------------------------------------------
module tb_tt_sweep_capture;

  typedef enum int {M_AND, M_XOR, M_ONE, M_ZERO, M_X0, M_NX3, M_REG} mode_t;

  typedef struct {
    mode_t       mode;
    int          k;
    logic [15:0] exp_tt;
    int          lat;
    int          hold;
    bit          repulse;
    bit          start_at_hs;
  } vec_t;

  typedef struct {
    logic [15:0] tt;
    int          lat;
    int          ones;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        tt_ready = 1'b0;
  logic [2:0]  start_v  = 3'b000;
  logic [2:0]  busy_v;
  logic [2:0]  fn_y_v;
  logic [2:0]  tt_valid_v;
  logic [3:0]  fn_x_v [3];
  logic [15:0] tt_v   [3];
`ifdef TT_SWEEP_POPCOUNT_EN
  logic [4:0]  ones_v [3];
`endif

  mode_t cur_mode = M_AND;
  int    checks   = 0;
  int    errors   = 0;
  exp_t  sb_q[$];
  vec_t  vecs[8];

  always #5 clk = ~clk;

  // Reference function models, chosen by cur_mode.
  function automatic logic model_y(input mode_t m, input logic [3:0] x);
    case (m)
      M_AND:   return &x;
      M_XOR:   return ^x;
      M_ONE:   return 1'b1;
      M_X0:    return x[0];
      M_NX3:   return ~x[3];
      M_REG:   return x[0] & x[3];
      default: return 1'b0;
    endcase
  endfunction

  // One DUT per SETTLE value; M_REG routes fn_y through a one-cycle register
  // to model a function block with a pipeline stage.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic y_reg = 1'b0;

    always @(posedge clk) y_reg <= fn_x_v[g][0] & fn_x_v[g][3];

    assign fn_y_v[g] = (cur_mode == M_REG) ? y_reg : model_y(cur_mode, fn_x_v[g]);

    tt_sweep_capture #(
      .N_IN   (4),
      .SETTLE (g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .busy     (busy_v[g]),
      .fn_x     (fn_x_v[g]),
      .fn_y     (fn_y_v[g]),
      .tt       (tt_v[g]),
      .tt_valid (tt_valid_v[g]),
`ifdef TT_SWEEP_POPCOUNT_EN
      .tt_ones  (ones_v[g]),
`endif
      .tt_ready (tt_ready)
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // fn_x on the SETTLE=1 instance must be held exactly two cycles for every
  // minterm that is followed by another one.
  bit         run_active = 1'b0;
  int         run_len    = 0;
  logic [3:0] run_x      = 4'd0;

  always @(posedge clk) begin
    #2;
    if (rst || (busy_v[1] !== 1'b1)) begin
      run_active = 1'b0;
    end else if (!run_active) begin
      run_active = 1'b1;
      run_x      = fn_x_v[1];
      run_len    = 1;
    end else if (fn_x_v[1] == run_x) begin
      run_len++;
    end else begin
      checkOutput("fn_x_hold_len", 32'(run_len), 32'd2);
      run_x   = fn_x_v[1];
      run_len = 1;
    end
  end

  // Push the expected result, then pulse start for one accepting edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    e.tt   = v.exp_tt;
    e.lat  = v.lat;
    e.ones = $countones(v.exp_tt);
    sb_q.push_back(e);
    cur_mode      = v.mode;
    start_v[v.k]  = 1'b1;
    @(posedge clk); #1;
    start_v[v.k]  = 1'b0;
    checkOutput("busy_on_accept", 32'(busy_v[v.k]), 32'd1);
  endtask

  task automatic runVector(input vec_t v);
    int   cycles    = 0;
    int   stray     = 0;
    bit   pulsed    = 1'b0;
    bit   stable_ok = 1'b1;
    exp_t e;

    applyStimulus(v);

    while ((tt_valid_v[v.k] !== 1'b1) && (cycles < 400)) begin
      @(posedge clk); #1;
      cycles++;
      start_v[v.k] = 1'b0;
      if (v.repulse && !pulsed && (fn_x_v[v.k] == 4'd5)) begin
        start_v[v.k] = 1'b1;
        pulsed       = 1'b1;
      end
    end
    start_v[v.k] = 1'b0;
    if (v.repulse) checkOutput("repulse_reached_idx5", 32'(pulsed), 32'd1);

    e = sb_q.pop_front();
    checkOutput("valid_latency", 32'(cycles), 32'(e.lat));
    checkOutput("tt_value", 32'(tt_v[v.k]), 32'(e.tt));
`ifdef TT_SWEEP_POPCOUNT_EN
    checkOutput("tt_ones", 32'(ones_v[v.k]), 32'(e.ones));
`endif

    // Back-pressure: table, valid and busy must hold while tt_ready is low.
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      start_v[v.k] = 1'b0;
      if ((tt_valid_v[v.k] !== 1'b1) || (busy_v[v.k] !== 1'b1) || (tt_v[v.k] !== e.tt))
        stable_ok = 1'b0;
      if (v.repulse && (h == 1)) start_v[v.k] = 1'b1;
    end
    start_v[v.k] = 1'b0;
    checkOutput("hold_stable", 32'(stable_ok), 32'd1);

    tt_ready = 1'b1;
    if (v.start_at_hs) start_v[v.k] = 1'b1;
    @(posedge clk); #1;
    tt_ready     = 1'b0;
    start_v[v.k] = 1'b0;
    checkOutput("valid_after_hs", 32'(tt_valid_v[v.k]), 32'd0);
    checkOutput("busy_after_hs", 32'(busy_v[v.k]), 32'd0);
    checkOutput("tt_held_after_hs", 32'(tt_v[v.k]), 32'(e.tt));

    if (v.start_at_hs) begin
      repeat (40) begin
        @(posedge clk); #1;
        if ((busy_v[v.k] !== 1'b0) || (tt_valid_v[v.k] !== 1'b0)) stray++;
      end
      checkOutput("no_second_episode", 32'(stray), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v_rst;
    int   c;

    //          mode    k  tt        lat hold rep hs
    vecs[0] = '{M_AND,  1, 16'h8000, 33,  2, 1'b0, 1'b0};
    vecs[1] = '{M_XOR,  0, 16'h6996, 17,  2, 1'b0, 1'b0};
    vecs[2] = '{M_ONE,  2, 16'hFFFF, 49, 10, 1'b0, 1'b0};
    vecs[3] = '{M_REG,  1, 16'hAA00, 33,  2, 1'b0, 1'b0};
    vecs[4] = '{M_AND,  1, 16'h8000, 33,  4, 1'b1, 1'b1};
    vecs[5] = '{M_X0,   0, 16'hAAAA, 17,  1, 1'b0, 1'b0};
    vecs[6] = '{M_NX3,  2, 16'h00FF, 49,  1, 1'b0, 1'b0};
    vecs[7] = '{M_ZERO, 1, 16'h0000, 33,  1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checkOutput("reset_fn_x", 32'(fn_x_v[g]), 32'd0);
      checkOutput("reset_busy", 32'(busy_v[g]), 32'd0);
      checkOutput("reset_tt", 32'(tt_v[g]), 32'd0);
      checkOutput("reset_tt_valid", 32'(tt_valid_v[g]), 32'd0);
`ifdef TT_SWEEP_POPCOUNT_EN
      checkOutput("reset_tt_ones", 32'(ones_v[g]), 32'd0);
`endif
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      runVector(vecs[i]);
      @(posedge clk); #1;
    end

    // Abort a sweep at idx 9, then confirm a fresh sweep still completes.
    v_rst = '{M_XOR, 1, 16'h6996, 33, 1, 1'b0, 1'b0};
    cur_mode   = M_XOR;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    c = 0;
    while ((fn_x_v[1] !== 4'd9) && (c < 100)) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("reach_idx9", 32'(fn_x_v[1]), 32'd9);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_fn_x", 32'(fn_x_v[1]), 32'd0);
    checkOutput("abort_busy", 32'(busy_v[1]), 32'd0);
    checkOutput("abort_tt", 32'(tt_v[1]), 32'd0);
    checkOutput("abort_tt_valid", 32'(tt_valid_v[1]), 32'd0);
`ifdef TT_SWEEP_POPCOUNT_EN
    checkOutput("abort_tt_ones", 32'(ones_v[1]), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    runVector(v_rst);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
